// File: rtl/data_path_muxs_pkg.sv
// -----------------------------------------------------------------------------
// data_path_muxs_pkg
// Select encodings for the datapath muxes driven by the hazard unit.
// Only the PC-source select lives here; other mux selects belong to their
// own owners.
// -----------------------------------------------------------------------------
package data_path_muxs_pkg;

    localparam int PCSRC_W = 3;

    localparam logic [PCSRC_W-1:0] SEL_LOAD_NXT_INSTR     = 3'd0; // PC + 4
    localparam logic [PCSRC_W-1:0] SEL_LOAD_JMP_ADDR      = 3'd1; // J/JAL target from IF/ID
    localparam logic [PCSRC_W-1:0] SEL_LOAD_JR_ADDR       = 3'd2; // JR register value
    localparam logic [PCSRC_W-1:0] SEL_LOAD_NXT_PC_EX_MEM = 3'd3; // corrected PC after mispredict

endpackage

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for hazard_ctrl_unit: the debug FSM state enum,
// the load-use counter width and the latch-count helper.
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        IWAIT   = 3'd1,
        DWAIT   = 3'd2,
        LDSTALL = 3'd3,
        HALTED  = 3'd4
    } hazard_state_t;

    // Load-use counter holds up to LOAD_USE_CYC-1 (max 6).
    localparam int LD_CNT_W = 3;

    // Pipeline with N stages has N-1 inter-stage latches.
    function automatic int num_latch(input int num_stages);
        return num_stages - 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all ones. Asynchronous active-high clear.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high clear
//   inc  - count enable for this cycle
//   cnt  - current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard controller for an N-stage pipelined MIPS core. Produces per-latch
// enable/flush vectors, the PC-source select and the PC enable from cache
// handshakes, branch/jump decode and a load-use detector.
//
// Optional build macro: HAZARD_PERF_EN
//   defined   -> stall_cycles / flush_events are saturating perf counters
//   undefined -> both outputs tied to 0, no counter flops
//
// Ports:
//   CLK, RST                     clock, async active-high reset
//   ihit, dhit                   fetch / data access complete
//   dmemREN, dmemWEN             data access pending in MEM
//   halt_wb                      HALT reached WB (sets sticky halt)
//   br_mispredict                branch in latch BR_STAGE resolved wrong
//   jmp_id, jr_id                J/JAL or JR sitting in IF/ID
//   rs_id, rt_id, uses_rs_id,
//   uses_rt_id                   IF/ID source operands
//   load_ex, dest_ex             load and its destination in ID/EX
//   enable, flush                per-latch write enable / sync clear (0=IF/ID)
//   enable_pc                    PC write enable
//   PCSrc                        PC mux select (data_path_muxs_pkg)
//   state                        registered debug state
//   stall_cycles, flush_events   perf counters
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
    import hazard_pkg::*;
    import data_path_muxs_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int BR_STAGE     = 3,
    parameter int LOAD_USE_CYC = 1,
    parameter int REG_AW       = 5,
    parameter int PERF_W       = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                ihit,
    input  logic                                dhit,
    input  logic                                dmemREN,
    input  logic                                dmemWEN,
    input  logic                                halt_wb,
    input  logic                                br_mispredict,
    input  logic                                jmp_id,
    input  logic                                jr_id,
    input  logic [REG_AW-1:0]                   rs_id,
    input  logic [REG_AW-1:0]                   rt_id,
    input  logic                                uses_rs_id,
    input  logic                                uses_rt_id,
    input  logic                                load_ex,
    input  logic [REG_AW-1:0]                   dest_ex,
    output logic [num_latch(NUM_STAGES)-1:0]    enable,
    output logic [num_latch(NUM_STAGES)-1:0]    flush,
    output logic                                enable_pc,
    output logic [PCSRC_W-1:0]                  PCSrc,
    output hazard_state_t                       state,
    output logic [PERF_W-1:0]                   stall_cycles,
    output logic [PERF_W-1:0]                   flush_events
);

    localparam int NUM_LATCH = num_latch(NUM_STAGES);
    localparam logic [LD_CNT_W-1:0] LD_INIT = LD_CNT_W'(LOAD_USE_CYC - 1);

    logic                halted_q;
    logic [LD_CNT_W-1:0] ld_cnt_q;
    logic [LD_CNT_W-1:0] ld_cnt_d;
    hazard_state_t       state_q;

    logic mem_req;
    logic move;
    logic lu_match;
    logic lu_detect;
    logic lu_stall;
    logic lu_active;

    // A pending data access owns the pipeline: only dhit can advance it,
    // even if ihit is also high.
    assign mem_req = dmemREN | dmemWEN;
    assign move    = !halted_q & (mem_req ? dhit : ihit);

    // Register 0 is hardwired, so a load to $0 never creates a dependency.
    assign lu_match  = load_ex & (dest_ex != '0) &
                       ((uses_rs_id & (rs_id == dest_ex)) |
                        (uses_rt_id & (rt_id == dest_ex)));
    // New detection only when no earlier stall is still counting down.
    assign lu_detect = (ld_cnt_q == '0) & lu_match;
    assign lu_stall  = lu_detect | (ld_cnt_q != '0);
    // A mispredict squashes the consumer, so the stall is moot.
    assign lu_active = lu_stall & !br_mispredict;

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        enable    = {NUM_LATCH{move}};
        enable_pc = move;
        flush     = '0;
        PCSrc     = SEL_LOAD_NXT_INSTR;
        if (RST) begin
            enable    = '0;
            enable_pc = 1'b0;
            flush     = '1;
        end else if (move) begin
            if (br_mispredict) begin
                for (int i = 0; i < NUM_LATCH; i++)
                    if (i < BR_STAGE) flush[i] = 1'b1;
                PCSrc = SEL_LOAD_NXT_PC_EX_MEM;
            end else if (lu_stall) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX.
                enable_pc = 1'b0;
                enable[0] = 1'b0;
                flush[1]  = 1'b1;
            end else if (jmp_id) begin
                PCSrc    = SEL_LOAD_JMP_ADDR;
                flush[0] = 1'b1;
            end else if (jr_id) begin
                PCSrc    = SEL_LOAD_JR_ADDR;
                flush[0] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Load-use countdown: only advances on move cycles so memory waits
    // stretch the stall instead of eating it.
    // -------------------------------------------------------------------------
    always_comb begin
        ld_cnt_d = ld_cnt_q;
        if (move) begin
            if (br_mispredict)        ld_cnt_d = '0;
            else if (lu_detect)       ld_cnt_d = LD_INIT;
            else if (ld_cnt_q != '0)  ld_cnt_d = ld_cnt_q - LD_CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Sticky halt, load-use counter and debug FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halted_q <= 1'b0;
            ld_cnt_q <= '0;
            state_q  <= RUN;
        end else begin
            halted_q <= halted_q | halt_wb;
            ld_cnt_q <= ld_cnt_d;
            if (halt_wb || halted_q || state_q == HALTED)
                state_q <= HALTED;
            else if (mem_req && !dhit)
                state_q <= DWAIT;
            else if (!ihit)
                state_q <= IWAIT;
            else if (lu_active)
                state_q <= LDSTALL;
            else
                state_q <= RUN;
        end
    end

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Perf counters
    // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (!move & !halted_q) | lu_active;
    assign flush_inc = |flush;

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (stall_inc),
        .cnt (stall_cycles)
    );

    sat_counter #(.W(PERF_W)) u_flush_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (flush_inc),
        .cnt (flush_events)
    );
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (5 stages, BR_STAGE=3, LOAD_USE_CYC=2).
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;
    import data_path_muxs_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit, dhit, dmemREN, dmemWEN, halt_wb, br_mispredict;
    logic        jmp_id, jr_id, uses_rs_id, uses_rt_id, load_ex;
    logic [4:0]  rs_id, rt_id, dest_ex;
    logic [3:0]  enable, flush;
    logic        enable_pc;
    logic [2:0]  PCSrc;
    hazard_state_t state;
    logic [31:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;
    logic [31:0] perf_base;

    always #5 CLK = ~CLK;

    hazard_ctrl_unit #(
        .NUM_STAGES(5), .BR_STAGE(3), .LOAD_USE_CYC(2), .REG_AW(5), .PERF_W(32)
    ) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt_wb(halt_wb),
        .br_mispredict(br_mispredict), .jmp_id(jmp_id), .jr_id(jr_id),
        .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .load_ex(load_ex), .dest_ex(dest_ex),
        .enable(enable), .flush(flush), .enable_pc(enable_pc), .PCSrc(PCSrc),
        .state(state), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr;
        ihit = 1; dhit = 0; dmemREN = 0; dmemWEN = 0; halt_wb = 0;
        br_mispredict = 0; jmp_id = 0; jr_id = 0;
        rs_id = 0; rt_id = 0; uses_rs_id = 0; uses_rt_id = 0;
        load_ex = 0; dest_ex = 0;
    endtask

    task automatic outs(input string tag, input logic [3:0] en, input logic [3:0] fl,
                        input logic epc, input logic [2:0] pcs);
        chk({tag, ".en"},  32'(enable),    32'(en));
        chk({tag, ".fl"},  32'(flush),     32'(fl));
        chk({tag, ".epc"}, 32'(enable_pc), 32'(epc));
        chk({tag, ".pcs"}, 32'(PCSrc),     32'(pcs));
    endtask

    initial begin
        clr();
        RST = 1;
        #2;
        outs("rst", 4'h0, 4'hf, 1'b0, SEL_LOAD_NXT_INSTR);
        chk("rst.st", 32'(state), 32'(RUN));
        chk("rst.sc", stall_cycles, 32'd0);

        // 1: reset release
        tick();
        RST = 0;
        #1;
        outs("t1", 4'hf, 4'h0, 1'b1, SEL_LOAD_NXT_INSTR);
        tick();
        chk("t1.st", 32'(state), 32'(RUN));

        // 2: load-use, 2 bubbles, stretched by a data wait
        load_ex = 1; dest_ex = 5; rs_id = 5; uses_rs_id = 1;
        #1;
        outs("t2a", 4'b1110, 4'b0010, 1'b0, SEL_LOAD_NXT_INSTR);
        tick();
        load_ex = 0; dmemREN = 1; dhit = 0;
        #1;
        chk("t2.st_ld", 32'(state), 32'(LDSTALL));
        outs("t2w", 4'h0, 4'h0, 1'b0, SEL_LOAD_NXT_INSTR);
        tick();
        dmemREN = 0;
        #1;
        chk("t2.st_dw", 32'(state), 32'(DWAIT));
        outs("t2b", 4'b1110, 4'b0010, 1'b0, SEL_LOAD_NXT_INSTR);
        tick();
        outs("t2c", 4'hf, 4'h0, 1'b1, SEL_LOAD_NXT_INSTR);

        // 3: mispredict overrides an active stall
        load_ex = 1; dest_ex = 7; rt_id = 7; uses_rt_id = 1;
        #1;
        outs("t3a", 4'b1110, 4'b0010, 1'b0, SEL_LOAD_NXT_INSTR);
        tick();
        clr();
        br_mispredict = 1;
        #1;
        outs("t3b", 4'hf, 4'b0111, 1'b1, SEL_LOAD_NXT_PC_EX_MEM);
        tick();
        br_mispredict = 0;
        #1;
        chk("t3.st", 32'(state), 32'(RUN));
        outs("t3c", 4'hf, 4'h0, 1'b1, SEL_LOAD_NXT_INSTR);

        // 4: data wait for 3 cycles
        dmemREN = 1; dhit = 0;
        #1;
        perf_base = stall_cycles;
        outs("t4w", 4'h0, 4'h0, 1'b0, SEL_LOAD_NXT_INSTR);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4.st", 32'(state), 32'(DWAIT));
        end
        dhit = 1; ihit = 0;
        #1;
        outs("t4h", 4'hf, 4'h0, 1'b1, SEL_LOAD_NXT_INSTR);
`ifdef HAZARD_PERF_EN
        chk("t4.sc", stall_cycles - perf_base, 32'd3);
`else
        chk("t4.sc", stall_cycles, 32'd0);
        chk("t4.fe", flush_events, 32'd0);
`endif
        tick();
        clr();

        // 5: jump/jr priority and gating
        jmp_id = 1; jr_id = 1;
        #1;
        outs("t5jj", 4'hf, 4'b0001, 1'b1, SEL_LOAD_JMP_ADDR);
        jmp_id = 0;
        #1;
        outs("t5jr", 4'hf, 4'b0001, 1'b1, SEL_LOAD_JR_ADDR);
        ihit = 0;
        #1;
        outs("t5nm", 4'h0, 4'h0, 1'b0, SEL_LOAD_NXT_INSTR);
        ihit = 1; jmp_id = 1; br_mispredict = 1;
        #1;
        outs("t5bj", 4'hf, 4'b0111, 1'b1, SEL_LOAD_NXT_PC_EX_MEM);
        br_mispredict = 0; load_ex = 1; dest_ex = 3; rs_id = 3; uses_rs_id = 1;
        #1;
        outs("t5lj", 4'b1110, 4'b0010, 1'b0, SEL_LOAD_NXT_INSTR);
        jmp_id = 0; uses_rs_id = 0;
        #1;
        chk("t5.nouse", 32'(enable_pc), 32'd1);
        dest_ex = 0; rs_id = 0; uses_rs_id = 1;
        #1;
        chk("t5.r0", 32'(enable_pc), 32'd1);
        clr();
        ihit = 0; dmemWEN = 1; dhit = 1;
        #1;
        chk("t5.dwin", 32'(enable), 32'hf);
        tick();
        clr();
        tick();

        // 6: halt then reset
        halt_wb = 1;
        #1;
        chk("t6.pre", 32'(enable), 32'hf);
        tick();
        halt_wb = 0;
        #1;
        outs("t6h", 4'h0, 4'h0, 1'b0, SEL_LOAD_NXT_INSTR);
        chk("t6.st", 32'(state), 32'(HALTED));
        br_mispredict = 1;
        tick();
        chk("t6.fl", 32'(flush), 32'd0);
        chk("t6.st2", 32'(state), 32'(HALTED));
        br_mispredict = 0;
        RST = 1;
        #1;
        outs("t6r", 4'h0, 4'hf, 1'b0, SEL_LOAD_NXT_INSTR);
        chk("t6.rst", 32'(state), 32'(RUN));
        tick();
        RST = 0;
        #1;
        outs("t6x", 4'hf, 4'h0, 1'b1, SEL_LOAD_NXT_INSTR);
        tick();
        chk("t6.run", 32'(state), 32'(RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the single-cycle-view hazard unit for the pipelined MIPS core.
- Generates per-latch enable/flush vectors for an N-stage pipeline, a PC-source select, and a PC enable.
- Sequential state: a memory-wait/halt FSM, a multi-cycle load-use stall counter, and a sticky halt.
- Sits between the cache interface (ihit/dhit), the decode/execute latches, and the PC/datapath muxes.

Parameters:
NUM_STAGES, 5, pipeline stages; NUM_LATCH = NUM_STAGES-1 latches, index 0 = IF/ID.
BR_STAGE, 3, latch holding the resolved branch; a mispredict flushes latches 0..BR_STAGE-1.
LOAD_USE_CYC, 1, bubbles inserted per load-use hazard (1..7).
REG_AW, 5, register-index width.
PERF_W, 32, perf counter width (used only with the optional feature).

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
ihit  in  1  instruction fetch complete
dhit  in  1  data access complete
dmemREN  in  1  data read pending in MEM
dmemWEN  in  1  data write pending in MEM
halt_wb  in  1  HALT reached WB
br_mispredict  in  1  branch in latch BR_STAGE resolved wrong
jmp_id  in  1  J/JAL in IF/ID
jr_id  in  1  JR in IF/ID
rs_id, rt_id  in  REG_AW  IF/ID source registers
uses_rs_id, uses_rt_id  in  1  source actually read
load_ex  in  1  load (dREN) in ID/EX
dest_ex  in  REG_AW  ID/EX destination register
enable  out  NUM_LATCH  per-latch write enable
flush  out  NUM_LATCH  per-latch synchronous clear
enable_pc  out  1  PC write enable
PCSrc  out  3  data_path_muxs_pkg select
state  out  hazard_state_t  FSM state (debug)
stall_cycles, flush_events  out  PERF_W  perf counters

Behaviour:
- move = !halted & (dmemREN|dmemWEN ? dhit : ihit). This term is combinational.
- Defaults: enable = {NUM_LATCH{move}}; enable_pc = move; flush = 0; PCSrc = SEL_LOAD_NXT_INSTR.
- While RST is high: enable = 0, enable_pc = 0, flush = all ones, PCSrc = SEL_LOAD_NXT_INSTR.
- On reset: state = RUN, ld_cnt = 0, halted = 0, counters = 0.
- Load-use detect (only when ld_cnt==0):
  - Condition: load_ex & dest_ex!=0 & ((uses_rs_id & rs_id==dest_ex) | (uses_rt_id & rt_id==dest_ex)).
  - On detect: ld_cnt <= LOAD_USE_CYC - 1 on the next move edge.
- While detect is true or ld_cnt>0 (and move): enable_pc = 0, enable[0] = 0, flush[1] = 1.
- ld_cnt decrements only on cycles where move=1; it freezes during memory waits.
- Priority, highest first (all gated by move; with move=0 no flush or redirect is issued):
  1. br_mispredict: flush[BR_STAGE-1:0] = 1; PCSrc = SEL_LOAD_NXT_PC_EX_MEM; ld_cnt <= 0; load-use suppressed; jmp/jr ignored.
  2. Load-use stall as above; jmp/jr ignored while the consumer is held.
  3. jmp_id: PCSrc = SEL_LOAD_JMP_ADDR, flush[0] = 1.
  4. jr_id: PCSrc = SEL_LOAD_JR_ADDR, flush[0] = 1. If jmp_id and jr_id are both set, jmp_id wins.
- halted is set on the edge where halt_wb=1 and stays set until RST. While halted: all enables 0, flushes 0.
- FSM (hazard_state_t), registered, evaluated each edge in priority order:
  - HALTED if halt_wb or halted;
  - else DWAIT if (dmemREN|dmemWEN) & !dhit;
  - else IWAIT if !ihit;
  - else LDSTALL if the load-use stall is active;
  - else RUN.
- HALTED is absorbing. The state output is informational only and does not gate outputs.
- Simultaneous dhit and ihit with a pending data request: data wins and move=1.
- A mispredict during a memory wait takes effect on the first move cycle.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined:
  - stall_cycles increments each cycle with !move & !halted, or with the load-use stall active.
  - flush_events increments each cycle in which any flush bit is set.
  - Both counters saturate at all ones and clear on RST.
- When undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- hazard_pkg: hazard_state_t enum {RUN, IWAIT, DWAIT, LDSTALL, HALTED}; localparam helpers for NUM_LATCH. PCSrc encodings remain in data_path_muxs_pkg.
- One sub-module, sat_counter (parameter W; inputs CLK, RST, inc; output cnt), instanced twice under HAZARD_PERF_EN.

Test Plan:
1. Reset release with ihit=1 and no hazards -> enable=4'b1111, flush=0, PCSrc=SEL_LOAD_NXT_INSTR, state=RUN one cycle later.
2. load_ex=1, dest_ex=5, rs_id=5, uses_rs_id=1, LOAD_USE_CYC=2 -> enable_pc=0, enable[0]=0, flush[1]=1 for exactly 2 move cycles; a dhit=0 wait between them extends the stall without consuming a count.
3. Stall active plus br_mispredict=1 (BR_STAGE=3) -> flush=4'b0111, PCSrc=SEL_LOAD_NXT_PC_EX_MEM, ld_cnt cleared, next cycle state=RUN.
4. dmemREN=1, dhit=0 for 3 cycles, then dhit=1 -> enable=0 and state=DWAIT for 3 cycles, enable all ones on the dhit cycle; with perf enabled, stall_cycles=3.
5. jmp_id=1 and jr_id=1 together with move=1 -> PCSrc=SEL_LOAD_JMP_ADDR, flush=4'b0001.
6. halt_wb pulse, then RST mid-halt -> enable stays 0 after the pulse with state=HALTED; RST forces flush all ones, then RUN resumes on release.
